detect_bus_arbiter: RTL and testbench

DETECT_BUS_ARBITER -- requirements
Module: detect_bus_arbiter

---
 rtl/detect_bus_arbiter.sv | 107 ++++++++++
 tb/tb_detect_bus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/detect_bus_arbiter.sv
// rtl/detect_bus_arbiter.sv - round-robin owner arbiter for a shared tristate detect line
// IDLE/GRANT/TURN FSM with a hold limit per owner and a one-cycle turnaround between owners.
module detect_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] oe,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    localparam int CW = $clog2(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    oe_n;
    logic [1:0]    gnt_n;
    logic          busy_n;
    logic          timeout_n;
    logic [1:0]    rr_win;
    logic [1:0]    idx;
    logic          hold_expired;

    // Scan downward so the lowest offset from ptr is the last, winning assignment.
    always_comb begin
        rr_win = ptr;
        idx    = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_win = idx;
            end
        end
    end

    assign hold_expired = (cnt == CW'(HOLD_MAX - 1));

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cnt_n     = cnt;
        gnt_n     = gnt_id;
        oe_n      = 4'b0000;
        busy_n    = 1'b0;
        timeout_n = 1'b0;
        case (state)
            IDLE, TURN: begin
                if (req != 4'b0000) begin
                    state_n = GRANT;
                    gnt_n   = rr_win;
                    ptr_n   = rr_win + 2'd1;
                    cnt_n   = '0;
                    oe_n    = 4'b0001 << rr_win;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (!req[gnt_id] || hold_expired) begin
                    state_n   = TURN;
                    // A drop coinciding with expiry is voluntary, so only a still-held req flags timeout.
                    timeout_n = req[gnt_id];
                end else begin
                    cnt_n  = cnt + CW'(1);
                    oe_n   = oe;
                    busy_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            gnt_id  <= 2'd0;
            oe      <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            gnt_id  <= gnt_n;
            oe      <= oe_n;
            busy    <= busy_n;
            timeout <= timeout_n;
        end
    end

endmodule

// File: tb/tb_detect_bus_arbiter.sv
// tb/tb_detect_bus_arbiter.sv - bench for detect_bus_arbiter
// Vector table, directed corner sequences and random traffic against a behavioural model.
module tb_detect_bus_arbiter;

    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] oe;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    detect_bus_arbiter #(.N_REQ(4), .HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .oe      (oe),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Behavioural model: owner index (-1 = nobody), cycles held, next search start.
    int   m_owner = -1;
    int   m_held  = 0;
    int   m_ptr   = 0;
    logic m_to    = 1'b0;
    int   run_len = 0;
    logic [3:0] prev_oe = 4'b0000;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_update(input logic r, input logic [3:0] q);
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner] || m_held == HOLD_MAX) begin
                m_to    = q[m_owner];
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else if (q != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && q[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
            end
            m_ptr  = (m_owner + 1) % 4;
            m_held = 1;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q);
        int exp_oe;
        rst = r;
        req = q;
        model_update(r, q);
        @(posedge clk);
        #1;
        exp_oe = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("model_oe", int'(oe), exp_oe);
        chk("model_busy", int'(busy), int'(m_owner >= 0));
        chk("model_timeout", int'(timeout), int'(m_to));
        if (m_owner >= 0) chk("model_gnt_id", int'(gnt_id), m_owner);
        chk("onehot_oe", int'($countones(oe) <= 1), 1);
        chk("busy_eq_or_oe", int'(busy), int'(|oe));
        if (oe != 4'b0000 && oe == prev_oe) run_len++;
        else run_len = (oe != 4'b0000) ? 1 : 0;
        chk("hold_len", int'(run_len <= HOLD_MAX), 1);
        prev_oe = oe;
    endtask

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic [3:0] oe;
        logic       busy;
        logic [1:0] gnt;
        logic       to;
    } vec_t;

    vec_t vt[20];

    initial begin
        logic [3:0] rq;
        int         owners[5];

        vt[0]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[2]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[3]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[4]  = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[7]  = '{1'b0, 4'b1001, 4'b1000, 1'b1, 2'd3, 1'b0};
        vt[8]  = '{1'b0, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[9]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0};
        vt[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[11] = '{1'b0, 4'b0011, 4'b0010, 1'b1, 2'd1, 1'b0};
        vt[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[13] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[14] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[15] = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[16] = '{1'b0, 4'b0101, 4'b0100, 1'b1, 2'd2, 1'b0};
        vt[17] = '{1'b0, 4'b1011, 4'b0000, 1'b0, 2'd0, 1'b0};
        vt[18] = '{1'b0, 4'b1011, 4'b1000, 1'b1, 2'd3, 1'b0};
        vt[19] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(vt[i].r, vt[i].q);
            chk($sformatf("vec%0d_oe", i), int'(oe), int'(vt[i].oe));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vt[i].busy));
            chk($sformatf("vec%0d_timeout", i), int'(timeout), int'(vt[i].to));
            if (vt[i].busy || vt[i].r) chk($sformatf("vec%0d_gnt_id", i), int'(gnt_id), int'(vt[i].gnt));
        end

        // All four requesting: each owner is cut off after HOLD_MAX cycles in rotation.
        step(1'b1, 4'b0000);
        owners = '{0, 1, 2, 3, 0};
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < HOLD_MAX; c++) begin
                step(1'b0, 4'b1111);
                chk($sformatf("rr%0d_c%0d_oe", g, c), int'(oe), 1 << owners[g]);
                chk($sformatf("rr%0d_c%0d_gnt", g, c), int'(gnt_id), owners[g]);
            end
            step(1'b0, 4'b1111);
            chk($sformatf("rr%0d_turn_oe", g), int'(oe), 0);
            chk($sformatf("rr%0d_turn_timeout", g), int'(timeout), 1);
        end

        // Owner drops on the very edge its hold limit is reached: voluntary release.
        step(1'b1, 4'b0000);
        for (int c = 0; c < HOLD_MAX; c++) step(1'b0, 4'b0010);
        chk("simul_last_oe", int'(oe), 4'b0010);
        step(1'b0, 4'b0000);
        chk("simul_turn_oe", int'(oe), 0);
        chk("simul_timeout", int'(timeout), 0);
        step(1'b0, 4'b0000);
        chk("simul_idle_timeout", int'(timeout), 0);

        // Reset mid-grant, then the pointer must restart at 0.
        step(1'b1, 4'b0000);
        for (int c = 0; c < 5; c++) step(1'b0, 4'b0100);
        step(1'b1, 4'b0100);
        chk("rstmid_oe", int'(oe), 0);
        chk("rstmid_busy", int'(busy), 0);
        step(1'b0, 4'b0010);
        chk("rstmid_regrant_oe", int'(oe), 4'b0010);
        chk("rstmid_regrant_gnt", int'(gnt_id), 1);
        for (int c = 0; c < 3; c++) step(1'b0, 4'b0100);
        step(1'b1, 4'b0000);
        step(1'b0, 4'b1100);
        chk("rst_ptr0_gnt", int'(gnt_id), 2);

        // Random traffic, biased toward holding req so hold limits are exercised.
        rq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 7) == 0) rq = rq ^ (4'b0001 << $urandom_range(0, 3));
            step($urandom_range(0, 99) == 0, rq);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
